// File: rtl/ov7670_emulador.sv
// ov7670_emulador
// Emulates the video side of an OV7670 camera: on request it emits one
// frame of VSYNC / HREF / PCLK / D timing with RGB565 pixels, high byte
// first.
//
// Configuration macro: PADRAO_BARRAS_EN
//   undefined -> pixel value is a 16-bit counter, cleared at frame start
//   defined   -> 8 vertical colour bars, each COLUMNS/8 pixels wide
//
// Ports
//   clock      in   system clock, the only clock
//   reset      in   asynchronous, active-low reset
//   iniciar    in   one-clock request to emit a frame (ignored while busy)
//   PWDN       in   power down, active high; aborts and silences outputs
//   VSYNC      out  frame sync, high during the vertical sync interval
//   HREF       out  high while a line's bytes are on D
//   PCLK       out  pixel clock, clock/2
//   D          out  video byte, 0x00 outside active lines
//   ocupado    out  frame in progress
//   fim_frame  out  one-clock pulse when the frame's final state is entered
//   db_estado  out  current FSM state code
//
// Handshake: iniciar is a single-cycle request with no ready; it is
// accepted only while ocupado=0 and PWDN=0, latched as pending, and the
// frame starts at the next PCLK-cycle start (the edge that drives PCLK 0).
module ov7670_emulador #(
    parameter int LINES     = 140,
    parameter int COLUMNS   = 320,
    parameter int HBLANK    = 16,
    parameter int VSYNC_LEN = 32,
    parameter int VBACK     = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       PWDN,
    output logic       VSYNC,
    output logic       HREF,
    output logic       PCLK,
    output logic [7:0] D,
    output logic       ocupado,
    output logic       fim_frame,
    output logic [3:0] db_estado
);

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int BYTES   = 2 * COLUMNS;
    localparam int GAP_MAX = max3(VSYNC_LEN, VBACK, HBLANK);
    localparam int BW      = cw(BYTES);
    localparam int LW      = cw(LINES);
    localparam int GW      = cw(GAP_MAX);

    typedef enum logic [3:0] {
        ST_OCIOSO     = 4'd0,
        ST_VSYNC_ALTO = 4'd1,
        ST_VBACK      = 4'd2,
        ST_LINHA      = 4'd3,
        ST_HBLANK     = 4'd4,
        ST_FIM        = 4'd5
    } estado_t;

    estado_t         estado, prox;
    logic            pclk_q;
    logic            pend;
    logic            fim_q;
    logic [GW-1:0]   gap_cnt;
    logic [BW-1:0]   byte_cnt;
    logic [LW-1:0]   line_cnt;
    logic [15:0]     pix_word;
    logic            tick;
    logic            ultimo_byte;
    logic            inicio_frame;

    // All FSM and data updates happen on the edge where PCLK falls, so the
    // outputs are stable across every PCLK rising edge.
    assign tick         = pclk_q & ~PWDN;
    assign ultimo_byte  = (byte_cnt == BW'(BYTES - 1));
    assign inicio_frame = tick && (estado == ST_OCIOSO) && pend;

    always_comb begin
        prox = estado;
        case (estado)
            ST_OCIOSO:     if (pend) prox = ST_VSYNC_ALTO;
            ST_VSYNC_ALTO: if (gap_cnt == GW'(VSYNC_LEN - 1)) prox = ST_VBACK;
            ST_VBACK:      if (gap_cnt == GW'(VBACK - 1)) prox = ST_LINHA;
            ST_LINHA:      if (ultimo_byte)
                               prox = (line_cnt == LW'(LINES - 1)) ? ST_FIM : ST_HBLANK;
            ST_HBLANK:     if (gap_cnt == GW'(HBLANK - 1)) prox = ST_LINHA;
            ST_FIM:        prox = ST_OCIOSO;
            default:       prox = ST_OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= ST_OCIOSO;
            pclk_q <= 1'b0;
            pend   <= 1'b0;
            fim_q  <= 1'b0;
        end else if (PWDN) begin
            estado <= ST_OCIOSO;
            pclk_q <= 1'b0;
            pend   <= 1'b0;
            fim_q  <= 1'b0;
        end else begin
            pclk_q <= ~pclk_q;
            fim_q  <= tick && (estado == ST_LINHA) && (prox == ST_FIM);
            if (tick) estado <= prox;
            if (inicio_frame)
                pend <= 1'b0;
            else if (iniciar && (estado == ST_OCIOSO))
                pend <= 1'b1;
        end
    end

    // Timing counters. gap_cnt is shared by the three blanking states and
    // restarts whenever the state changes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gap_cnt  <= '0;
            byte_cnt <= '0;
            line_cnt <= '0;
        end else if (PWDN) begin
            gap_cnt  <= '0;
            byte_cnt <= '0;
            line_cnt <= '0;
        end else if (tick) begin
            if (prox != estado)
                gap_cnt <= '0;
            else if (estado == ST_VSYNC_ALTO || estado == ST_VBACK || estado == ST_HBLANK)
                gap_cnt <= gap_cnt + 1'b1;

            if (inicio_frame) begin
                byte_cnt <= '0;
                line_cnt <= '0;
            end else if (estado == ST_LINHA) begin
                if (ultimo_byte) begin
                    byte_cnt <= '0;
                    line_cnt <= (line_cnt == LW'(LINES - 1)) ? '0 : line_cnt + 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

`ifdef PADRAO_BARRAS_EN
    localparam int BARW = COLUMNS / 8;
    localparam int PW   = cw(BARW);

    logic [PW-1:0] bar_pos;
    logic [2:0]    bar_idx;

    // Pixel position within the current bar plus the bar number; 8 bars
    // fill a line exactly, so bar_idx wraps 7->0 at the end of each line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (PWDN) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (tick) begin
            if (inicio_frame) begin
                bar_pos <= '0;
                bar_idx <= '0;
            end else if (estado == ST_LINHA && byte_cnt[0]) begin
                if (bar_pos == PW'(BARW - 1)) begin
                    bar_pos <= '0;
                    bar_idx <= bar_idx + 1'b1;
                end else begin
                    bar_pos <= bar_pos + 1'b1;
                end
            end
        end
    end

    always_comb begin
        pix_word = 16'h0000;
        case (bar_idx)
            3'd0: pix_word = 16'hFFFF;
            3'd1: pix_word = 16'hFFE0;
            3'd2: pix_word = 16'h07FF;
            3'd3: pix_word = 16'h07E0;
            3'd4: pix_word = 16'hF81F;
            3'd5: pix_word = 16'hF800;
            3'd6: pix_word = 16'h001F;
            default: pix_word = 16'h0000;
        endcase
    end
`else
    logic [15:0] pix_cnt;

    // Advances after the low byte of each pixel; runs on across lines.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pix_cnt <= '0;
        end else if (PWDN) begin
            pix_cnt <= '0;
        end else if (tick) begin
            if (inicio_frame)
                pix_cnt <= '0;
            else if (estado == ST_LINHA && byte_cnt[0])
                pix_cnt <= pix_cnt + 16'd1;
        end
    end

    assign pix_word = pix_cnt;
`endif

    // PWDN gates the outputs directly so power-down silences them at once.
    logic linha_ativa;
    assign linha_ativa = (estado == ST_LINHA) && !PWDN;

    assign PCLK      = pclk_q & ~PWDN;
    assign VSYNC     = (estado == ST_VSYNC_ALTO) && !PWDN;
    assign HREF      = linha_ativa;
    assign D         = linha_ativa ? (byte_cnt[0] ? pix_word[7:0] : pix_word[15:8]) : 8'h00;
    assign ocupado   = (estado != ST_OCIOSO) && !PWDN;
    assign fim_frame = fim_q & ~PWDN;
    assign db_estado = PWDN ? 4'd0 : estado;

endmodule

// File: doc/ov7670_emulador.md
OV7670_EMULADOR -- requirements
Module: ov7670_emulador

Interface
REQ-001 SHALL have parameter LINES, default 140, active lines per frame.
REQ-002 SHALL have parameter COLUMNS, default 320, pixels per line (multiple of 8, >=8).
REQ-003 SHALL have parameters HBLANK, default 16, VSYNC_LEN, default 32, and VBACK, default 16, all counted in PCLK cycles: inter-line gap, VSYNC width, VSYNC-fall-to-first-HREF gap.
REQ-004 SHALL have port clock  input  1  system clock, sole clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port iniciar  input  1  one-clock request to emit one frame.
REQ-007 SHALL have port PWDN  input  1  power down, active high.
REQ-008 SHALL have ports VSYNC, HREF, PCLK  output  1 each  sensor-side sync and pixel clock.
REQ-009 SHALL have port D  output  8  video byte.
REQ-010 SHALL have ports ocupado  output  1  frame in progress, and fim_frame  output  1  end-of-frame pulse.
REQ-011 SHALL have port db_estado  output  4  current FSM state code.

Function
REQ-012 PCLK SHALL toggle every clock while PWDN=0, giving a period of 2 clocks; a "PCLK cycle" begins on the clock edge that drives PCLK 0.
REQ-013 VSYNC, HREF and D SHALL change only at PCLK-cycle starts, so they are stable at every PCLK rising edge.
REQ-014 FSM states and codes: OCIOSO=0, VSYNC_ALTO=1, VBACK=2, LINHA=3, HBLANK=4, FIM=5.
REQ-015 An iniciar pulse in OCIOSO SHALL set a pending flag; at the next PCLK-cycle start the FSM SHALL enter VSYNC_ALTO and clear the flag.
REQ-016 iniciar SHALL be ignored while ocupado=1.
REQ-017 VSYNC_ALTO SHALL drive VSYNC=1 for VSYNC_LEN PCLK cycles, then go to VBACK.
REQ-018 VBACK SHALL drive VSYNC=0, HREF=0, D=0 for VBACK cycles, then go to LINHA.
REQ-019 LINHA SHALL drive HREF=1 for 2*COLUMNS cycles, one byte per cycle, RGB565 high byte first.
REQ-020 After the last byte of a line: line < LINES-1 -> HBLANK, otherwise -> FIM.
REQ-021 HBLANK SHALL drive HREF=0, D=0 for HBLANK cycles, then go to LINHA.
REQ-022 FIM SHALL last one PCLK cycle, pulse fim_frame for exactly one clock on entry, then go to OCIOSO.
REQ-023 ocupado SHALL be 1 in every state except OCIOSO.
REQ-024 Outside LINHA, D SHALL be 0x00 and HREF SHALL be 0.
REQ-025 Internal counters SHALL be sized with $clog2 of their bound and SHALL wrap to 0 at bound-1; no overflow is permitted.
REQ-026 Default pattern (macro absent): a 16-bit pixel counter cleared on entry to VSYNC_ALTO, incremented per pixel, wrapping mod 2^16 across lines.
REQ-027 PWDN=1 SHALL immediately abort any frame, force state OCIOSO, hold PCLK, VSYNC, HREF and D at 0, clear pending, and suppress fim_frame; on PWDN fall, PCLK resumes from 0.

Reset
REQ-028 Reset low SHALL asynchronously force state OCIOSO and PCLK=VSYNC=HREF=0, D=0x00, ocupado=0, fim_frame=0, db_estado=0, all counters and pending cleared.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no fim_frame; after release the block SHALL wait for a new iniciar.

Configuration
REQ-030 Macro PADRAO_BARRAS_EN, when defined, SHALL replace the counter pattern with 8 vertical bars, each COLUMNS/8 pixels wide, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000, identical on every line.
REQ-031 Without PADRAO_BARRAS_EN, REQ-026 applies and no bar logic SHALL be synthesized.

Verification (LINES=2, COLUMNS=8, HBLANK=2, VSYNC_LEN=3, VBACK=2)
REQ-032 One iniciar pulse -> VSYNC high exactly 3 PCLK cycles; frame = 40 PCLK cycles (80 clocks); exactly 2 HREF pulses of 16 cycles each; one fim_frame pulse; ocupado returns to 0.
REQ-033 Counter pattern, sampling D on PCLK rise -> line 0 bytes 00 00 00 01 ... 00 07; line 1 starts 00 08, ends 00 0F.
REQ-034 PADRAO_BARRAS_EN defined -> each line carries byte pairs FF FF, FF E0, 07 FF, 07 E0, F8 1F, F8 00, 00 1F, 00 00.
REQ-035 iniciar pulsed again during line 0 -> ignored; exactly one frame is emitted; a second iniciar after fim_frame -> second identical frame.
REQ-036 reset low during HBLANK -> all outputs 0 within the same cycle and no fim_frame; PWDN high during LINHA -> PCLK stops low and state is 0, and the next iniciar after PWDN fall emits a full frame.
